// File: rtl/addsub_pkg.sv
// Shared state encoding and operation-mode constants for the sequential add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/addsub_seq_unit_if.sv
// Request/result bundle between the register-file read side and the add/subtract unit.
interface addsub_seq_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] acc_data;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sub_out;
  logic             bi_sub;
  logic             zero;
  logic             ovf;

  modport master (
    output start, mode, acc_data, rd_data,
    input  busy, done, sub_out, bi_sub, zero, ovf
  );

  modport slave (
    input  start, mode, acc_data, rd_data,
    output busy, done, sub_out, bi_sub, zero, ovf
  );

endinterface

// File: rtl/addsub_chunk.sv
// One CHUNK-wide slice of the adder; the same instance is reused on every RUN cycle.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  input  logic             invB_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  logic [CHUNK-1:0] bEff;

  // Subtraction is a + ~b + 1, with the +1 arriving as the first slice's carry-in.
  assign bEff = b_i ^ {CHUNK{invB_i}};
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, bEff} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/addsub_seq_unit.sv
// Multi-cycle add/subtract: one CHUNK slice per clock with carry/borrow rippled across cycles,
// start/done handshake, and carry/zero/overflow flags captured on completion.
module addsub_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  addsub_seq_unit_if.slave bus
);

  import addsub_pkg::*;

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : gBadParams
    $error("addsub_seq_unit: WIDTH must be a positive multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] accOp_q, accOp_d;
  logic [WIDTH-1:0] rdOp_q, rdOp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             biSub_q, biSub_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] aChunk, bChunk, sumChunk;
  logic             chunkCout;
  logic             bMsb;
  logic [WIDTH-1:0] resultNext;

  always_comb begin
    aChunk = '0;
    bChunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) begin
        aChunk = accOp_q[k*CHUNK +: CHUNK];
        bChunk = rdOp_q[k*CHUNK +: CHUNK];
      end
    end
  end

  addsub_chunk #(.CHUNK(CHUNK)) uChunk (
    .a_i    (aChunk),
    .b_i    (bChunk),
    .cin_i  (carry_q),
    .invB_i (mode_q == MODE_SUB),
    .sum_o  (sumChunk),
    .cout_o (chunkCout)
  );

  // Sign bit of the effective second operand, needed for overflow on the top slice.
  assign bMsb = bChunk[CHUNK-1] ^ (mode_q == MODE_SUB);

  always_comb begin
    state_d    = state_q;
    accOp_d    = accOp_q;
    rdOp_d     = rdOp_q;
    result_d   = result_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    carry_d    = carry_q;
    biSub_d    = biSub_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    resultNext = result_q;

    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) begin
        resultNext[k*CHUNK +: CHUNK] = sumChunk;
      end
    end

    case (state_q)
      RUN: begin
        result_d = resultNext;
        carry_d  = chunkCout;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
          biSub_d = (mode_q == MODE_ADD) ? chunkCout : ~chunkCout;
          zero_d  = (resultNext == '0);
          ovf_d   = (aChunk[CHUNK-1] == bMsb) && (sumChunk[CHUNK-1] != aChunk[CHUNK-1]);
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
      default: begin
        if (bus.start) begin
          accOp_d = bus.acc_data;
          rdOp_d  = bus.rd_data;
          mode_d  = bus.mode;
          idx_d   = '0;
          carry_d = (bus.mode == MODE_SUB);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      accOp_q  <= '0;
      rdOp_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      biSub_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      accOp_q  <= accOp_d;
      rdOp_q   <= rdOp_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      biSub_q  <= biSub_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.sub_out = result_q;
  assign bus.bi_sub  = biSub_q;
  assign bus.zero    = zero_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_addsub_seq_unit.sv
// Directed checks of the sequential add/subtract unit: a 32-bit/8-bit-slice instance and a
// 16-bit single-slice instance sharing clock and reset.
module tb_addsub_seq_unit;

  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  addsub_seq_unit_if #(.WIDTH(32)) if32 ();
  addsub_seq_unit_if #(.WIDTH(16)) if16 ();

  addsub_seq_unit #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32.slave)
  );

  addsub_seq_unit #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  always #5 clk = ~clk;

  // Starts one 32-bit operation, scrambles the inputs after acceptance, and returns at the
  // falling edge of the first cycle with done high (cycle 1 = cycle after the accepting edge).
  task automatic runOp32(input logic [31:0] acc, input logic [31:0] rd, input logic md,
                         output int doneCyc, output int busyCnt);
    @(negedge clk);
    if32.acc_data = acc;
    if32.rd_data  = rd;
    if32.mode     = md;
    if32.start    = 1'b1;
    @(posedge clk);
    #1;
    if32.start    = 1'b0;
    if32.acc_data = ~acc;
    if32.rd_data  = ~rd;
    if32.mode     = ~md;
    doneCyc = 0;
    busyCnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if32.busy) busyCnt++;
      if (if32.done) begin
        doneCyc = c;
        break;
      end
    end
  endtask

  task automatic runOp16(input logic [15:0] acc, input logic [15:0] rd, input logic md,
                         output int doneCyc, output int busyCnt);
    @(negedge clk);
    if16.acc_data = acc;
    if16.rd_data  = rd;
    if16.mode     = md;
    if16.start    = 1'b1;
    @(posedge clk);
    #1;
    if16.start    = 1'b0;
    if16.acc_data = ~acc;
    if16.rd_data  = ~rd;
    doneCyc = 0;
    busyCnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if16.busy) busyCnt++;
      if (if16.done) begin
        doneCyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({if32.busy, if32.done, if32.bi_sub, if32.zero, if32.ovf} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset32.status: got %b expected 00000",
               {if32.busy, if32.done, if32.bi_sub, if32.zero, if32.ovf});
    end
    compared++;
    if (if32.sub_out !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset32.sub_out: got %h expected 00000000", if32.sub_out);
    end
    compared++;
    if ({if16.busy, if16.done, if16.bi_sub, if16.zero, if16.ovf} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset16.status: got %b expected 00000",
               {if16.busy, if16.done, if16.bi_sub, if16.zero, if16.ovf});
    end
    compared++;
    if (if16.sub_out !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL reset16.sub_out: got %h expected 0000", if16.sub_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_sub_basic;
    int doneCyc, busyCnt;
    runOp32(32'd45, 32'd23, MODE_SUB, doneCyc, busyCnt);
    compared++;
    if (doneCyc !== 5) begin
      mismatched++;
      $display("[TB] FAIL sub_basic.latency: got %0d expected 5", doneCyc);
    end
    compared++;
    if (busyCnt !== 4) begin
      mismatched++;
      $display("[TB] FAIL sub_basic.busy_cycles: got %0d expected 4", busyCnt);
    end
    compared++;
    if (if32.sub_out !== 32'd22) begin
      mismatched++;
      $display("[TB] FAIL sub_basic.sub_out: got %h expected %h", if32.sub_out, 32'd22);
    end
    compared++;
    if ({if32.bi_sub, if32.zero, if32.ovf} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL sub_basic.flags: got %b expected 000", {if32.bi_sub, if32.zero, if32.ovf});
    end
    @(negedge clk);
    compared++;
    if ({if32.done, if32.busy} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL sub_basic.done_one_cycle: got %b expected 00", {if32.done, if32.busy});
    end
    compared++;
    if (if32.sub_out !== 32'd22) begin
      mismatched++;
      $display("[TB] FAIL sub_basic.sub_out_held: got %h expected %h", if32.sub_out, 32'd22);
    end
  endtask

  task automatic test_borrow;
    int doneCyc, busyCnt;
    runOp32(32'd23, 32'd45, MODE_SUB, doneCyc, busyCnt);
    compared++;
    if (if32.sub_out !== 32'hFFFF_FFEA || doneCyc !== 5) begin
      mismatched++;
      $display("[TB] FAIL borrow.sub_out: got %h (cycle %0d) expected ffffffea (cycle 5)",
               if32.sub_out, doneCyc);
    end
    compared++;
    if ({if32.bi_sub, if32.zero, if32.ovf} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL borrow.flags: got %b expected 100", {if32.bi_sub, if32.zero, if32.ovf});
    end
  endtask

  task automatic test_add_flags;
    int doneCyc, busyCnt;
    runOp32(32'hFFFF_FFFF, 32'd1, MODE_ADD, doneCyc, busyCnt);
    compared++;
    if (if32.sub_out !== 32'h0 || doneCyc !== 5) begin
      mismatched++;
      $display("[TB] FAIL add_wrap.sub_out: got %h (cycle %0d) expected 00000000 (cycle 5)",
               if32.sub_out, doneCyc);
    end
    compared++;
    if ({if32.bi_sub, if32.zero, if32.ovf} !== 3'b110) begin
      mismatched++;
      $display("[TB] FAIL add_wrap.flags: got %b expected 110", {if32.bi_sub, if32.zero, if32.ovf});
    end
    runOp32(32'h7FFF_FFFF, 32'd1, MODE_ADD, doneCyc, busyCnt);
    compared++;
    if (if32.sub_out !== 32'h8000_0000 || doneCyc !== 5) begin
      mismatched++;
      $display("[TB] FAIL add_ovf.sub_out: got %h (cycle %0d) expected 80000000 (cycle 5)",
               if32.sub_out, doneCyc);
    end
    compared++;
    if ({if32.bi_sub, if32.zero, if32.ovf} !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL add_ovf.flags: got %b expected 001", {if32.bi_sub, if32.zero, if32.ovf});
    end
  endtask

  task automatic test_back_to_back;
    int doneCyc;
    @(negedge clk);
    if32.acc_data = 32'd45;
    if32.rd_data  = 32'd23;
    if32.mode     = MODE_SUB;
    if32.start    = 1'b1;
    @(posedge clk);
    #1;
    if32.start = 1'b0;
    doneCyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if32.done) begin
        doneCyc = c;
        break;
      end
      if (c == 2) begin
        if32.acc_data = 32'd1;
        if32.rd_data  = 32'd1;
        if32.start    = 1'b1;
      end
      if (c == 3) if32.start = 1'b0;
    end
    compared++;
    if (doneCyc !== 5 || if32.sub_out !== 32'd22) begin
      mismatched++;
      $display("[TB] FAIL ignore_start.result: got %h (cycle %0d) expected 00000016 (cycle 5)",
               if32.sub_out, doneCyc);
    end
    // Request issued during the DONE cycle must be taken immediately.
    if32.acc_data = 32'd100;
    if32.rd_data  = 32'd100;
    if32.mode     = MODE_SUB;
    if32.start    = 1'b1;
    @(negedge clk);
    if32.start = 1'b0;
    compared++;
    if ({if32.busy, if32.done} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL b2b.accepted: busy,done got %b expected 10", {if32.busy, if32.done});
    end
    doneCyc = 0;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (if32.done) begin
        doneCyc = c;
        break;
      end
    end
    compared++;
    if (doneCyc !== 5 || if32.sub_out !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL b2b.result: got %h (cycle %0d) expected 00000000 (cycle 5)",
               if32.sub_out, doneCyc);
    end
    compared++;
    if ({if32.bi_sub, if32.zero, if32.ovf} !== 3'b010) begin
      mismatched++;
      $display("[TB] FAIL b2b.flags: got %b expected 010", {if32.bi_sub, if32.zero, if32.ovf});
    end
  endtask

  task automatic test_reset_midrun;
    int doneSeen, doneCyc, busyCnt;
    @(negedge clk);
    if32.acc_data = 32'd23;
    if32.rd_data  = 32'd45;
    if32.mode     = MODE_SUB;
    if32.start    = 1'b1;
    @(posedge clk);
    #1;
    if32.start = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    compared++;
    if ({if32.busy, if32.done, if32.bi_sub, if32.zero, if32.ovf} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL midrun_reset.status: got %b expected 00000",
               {if32.busy, if32.done, if32.bi_sub, if32.zero, if32.ovf});
    end
    compared++;
    if (if32.sub_out !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL midrun_reset.sub_out: got %h expected 00000000", if32.sub_out);
    end
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if32.done || if32.busy) doneSeen++;
    end
    compared++;
    if (doneSeen !== 0) begin
      mismatched++;
      $display("[TB] FAIL midrun_reset.no_done: got %0d active cycles expected 0", doneSeen);
    end
    runOp32(32'd45, 32'd23, MODE_SUB, doneCyc, busyCnt);
    compared++;
    if (if32.sub_out !== 32'd22 || doneCyc !== 5) begin
      mismatched++;
      $display("[TB] FAIL midrun_reset.recover: got %h (cycle %0d) expected 00000016 (cycle 5)",
               if32.sub_out, doneCyc);
    end
  endtask

  task automatic test_single_slice;
    int doneCyc, busyCnt;
    runOp16(16'h8000, 16'h0001, MODE_SUB, doneCyc, busyCnt);
    compared++;
    if (doneCyc !== 2 || busyCnt !== 1) begin
      mismatched++;
      $display("[TB] FAIL single.latency: got done cycle %0d busy %0d expected 2 and 1",
               doneCyc, busyCnt);
    end
    compared++;
    if (if16.sub_out !== 16'h7FFF) begin
      mismatched++;
      $display("[TB] FAIL single.sub_out: got %h expected 7fff", if16.sub_out);
    end
    compared++;
    if ({if16.bi_sub, if16.zero, if16.ovf} !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL single.flags: got %b expected 001", {if16.bi_sub, if16.zero, if16.ovf});
    end
    runOp16(16'hFFFF, 16'h0001, MODE_ADD, doneCyc, busyCnt);
    compared++;
    if (if16.sub_out !== 16'h0000 || {if16.bi_sub, if16.zero, if16.ovf} !== 3'b110) begin
      mismatched++;
      $display("[TB] FAIL single.add_wrap: got %h flags %b expected 0000 flags 110",
               if16.sub_out, {if16.bi_sub, if16.zero, if16.ovf});
    end
  endtask

  initial begin
    rst           = 1'b1;
    if32.start    = 1'b0;
    if32.mode     = MODE_SUB;
    if32.acc_data = '0;
    if32.rd_data  = '0;
    if16.start    = 1'b0;
    if16.mode     = MODE_SUB;
    if16.acc_data = '0;
    if16.rd_data  = '0;

    test_reset();
    test_sub_basic();
    test_borrow();
    test_add_flags();
    test_back_to_back();
    test_reset_midrun();
    test_single_slice();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
